fx3_stream_arb: RTL and testbench
=================================

Name: fx3_stream_arb

Overview:
- Packet-granular round-robin arbiter. Shares the single 16-bit stream input of the FX3 transmit path (fx3_tx) between NUM_CH stream sources, e.g. usb_framer instances and debug/readback streams.
- Grants one source at a time and holds the grant until that source's last word.
- Enforces a maximum packet length and reports activity and status to software.

Parameters:
- NUM_CH, 4, number of source streams (2..8).
- MAX_PKT_LEN, 256, maximum words per output packet before a forced split (2..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- stream_s_data_i  in  16*NUM_CH  source data; channel k occupies [16k+15:16k].
- stream_s_valid_i  in  NUM_CH  per-source valid.
- stream_s_last_i  in  NUM_CH  per-source end-of-packet.
- stream_s_ready_o  out  NUM_CH  per-source ready.
- stream_m_data_o  out  16  data to fx3_tx.
- stream_m_valid_o  out  1  valid to fx3_tx.
- stream_m_last_o  out  1  end-of-packet to fx3_tx.
- stream_m_ready_i  in  1  ready from fx3_tx.
- ch_en_i  in  NUM_CH  per-channel arbitration enable.
- grant_o  out  NUM_CH  one-hot current grant; all zero when idle.
- busy_o  out  1  high while in any state other than IDLE.
- pkt_split_o  out  1  one-cycle pulse when a packet is force-terminated at MAX_PKT_LEN.

Behaviour:
- Handshake definitions:
  - A word transfers on the output when stream_m_valid_o && stream_m_ready_i.
  - A word transfers on channel k when stream_s_valid_i[k] && stream_s_ready_o[k].
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_grant = NUM_CH-1, so channel 0 has first priority.
  - Word counter 0.
- Reset asserted mid-packet abandons the packet. The next cycle shows valid=0, all ready=0 and grant=0. No last word is emitted.
- States are IDLE, HDR (only with the optional feature) and XFER.
- IDLE:
  - The candidate set is stream_s_valid_i & ch_en_i.
  - Pick the first candidate searching cyclically from last_grant+1.
  - If one exists, register grant_o = onehot(pick) and last_grant = pick, then move to XFER (or HDR).
  - All outputs are inactive in IDLE, so there is exactly one bubble cycle between packets.
- XFER (zero-latency combinational passthrough from the granted channel g):
  - m_data = s_data[g].
  - m_valid = s_valid[g].
  - s_ready[g] = m_ready.
  - All other s_ready are 0.
  - m_last = s_last[g] || (cnt == MAX_PKT_LEN-1).
- Word counter:
  - cnt increments on each output transfer.
  - On the transfer carrying m_last: cnt clears, grant clears, return to IDLE.
- Forced split (cnt == MAX_PKT_LEN-1 and s_last[g]=0):
  - m_last is asserted anyway and pkt_split_o pulses in the cycle after that transfer.
  - The remainder of the source packet competes as a new packet in round-robin.
- Deasserting ch_en_i[g] mid-packet does not abort; it only affects the next arbitration.
- No output transfers occur while m_ready=0; stalls of any length are legal.
- Valid must not depend on ready.
- A single-word packet (s_last on the first word) is legal and gives grant duration 1 transfer.
- If only one channel requests, it is re-granted after each bubble.

Optional Feature:
- Macro FX3_STREAM_ARB_HDR_EN.
- When defined:
  - After the grant in IDLE, the state goes to HDR.
  - HDR emits one header word {8'hC5, 8-bit channel index}, m_valid=1, m_last=0, all s_ready=0.
  - It advances to XFER on m_ready.
  - The header is not counted toward MAX_PKT_LEN.
  - A forced-split remainder gets its own header when re-granted.
- When undefined:
  - The HDR state and header logic are absent.
  - IDLE goes directly to XFER.

Decomposition:
- Package fx3_stream_arb_pkg holds:
  - the state encoding;
  - the HDR_MAGIC = 8'hC5 constant;
  - a clog2 function for the pointer and counter widths.
- One sub-module, fx3_rr_picker: combinational cyclic priority pick from (request vector, last_grant), outputting a found flag and an index.

Test Plan:
- Ch0 and ch2 each present a 4-word packet simultaneously after reset, m_ready=1 -> ch0 words out, last on word 4, one bubble, then ch2 words out; grant_o = 0001 then 0100.
- All 4 channels continuously valid with 3-word packets -> grant order 0,1,2,3,0; no output word interleaving between channels.
- MAX_PKT_LEN=8, ch1 sends a 10-word packet -> output last on word 8 and pkt_split_o pulses once; after re-arbitration the remaining 2 words go out with last on the final word.
- Ch0 granted, m_ready toggled 1,0,0,1 per cycle -> s_ready[0] mirrors m_ready and data is held stable while m_ready=0; no loss or duplication versus a scoreboard.
- ch_en_i=1101 with all channels valid -> channel 1 is never granted; clearing ch_en_i[0] mid-packet still completes the ch0 packet.
- With FX3_STREAM_ARB_HDR_EN, ch3 packet 0x1111,0x2222 -> output 0xC503, 0x1111, 0x2222 with last on 0x2222. Separately, rst asserted mid-packet -> valid, ready and grant are 0 the next cycle.

Source files
------------

// File: rtl/fx3_stream_arb_pkg.sv
// Shared types and helpers for the fx3_stream_arb packet arbiter.
// The HDR state exists only when FX3_STREAM_ARB_HDR_EN is defined.
package fx3_stream_arb_pkg;

`ifdef FX3_STREAM_ARB_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd2
  } state_t;
`endif

  localparam logic [7:0] HDR_MAGIC = 8'hC5;

  // Ceiling log2, never below 1 so a width is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fx3_rr_picker.sv
// Combinational cyclic priority pick: first set request bit searching
// upward from last+1, wrapping around.
module fx3_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/fx3_stream_arb.sv
// Packet-granular round-robin arbiter feeding the FX3 transmit stream.
// Define FX3_STREAM_ARB_HDR_EN to prefix each granted packet with a header word.
module fx3_stream_arb
  import fx3_stream_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*NUM_CH-1:0] stream_s_data_i,
  input  logic [NUM_CH-1:0]    stream_s_valid_i,
  input  logic [NUM_CH-1:0]    stream_s_last_i,
  output logic [NUM_CH-1:0]    stream_s_ready_o,
  output logic [15:0]          stream_m_data_o,
  output logic                 stream_m_valid_o,
  output logic                 stream_m_last_o,
  input  logic                 stream_m_ready_i,
  input  logic [NUM_CH-1:0]    ch_en_i,
  output logic [NUM_CH-1:0]    grant_o,
  output logic                 busy_o,
  output logic                 pkt_split_o
);

  localparam int PW = clog2(NUM_CH);
  localparam int CW = clog2(MAX_PKT_LEN);

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [PW-1:0]     last_grant_reg, last_grant_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              split_reg, split_next;

  logic [15:0]       ch_data [NUM_CH];
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic              sel_valid, sel_last, at_max, xfer_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = stream_s_data_i[16*gi +: 16];
    end
  endgenerate

  fx3_rr_picker #(
    .N (NUM_CH),
    .W (PW)
  ) u_picker (
    .req   (stream_s_valid_i & ch_en_i),
    .last  (last_grant_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // last_grant_reg doubles as the index of the channel currently granted.
  assign sel_valid = stream_s_valid_i[last_grant_reg];
  assign sel_last  = stream_s_last_i[last_grant_reg];
  assign at_max    = (cnt_reg == CW'(MAX_PKT_LEN - 1));
  assign xfer_last = sel_last || at_max;

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    cnt_next         = cnt_reg;
    split_next       = 1'b0;
    stream_m_data_o  = '0;
    stream_m_valid_o = 1'b0;
    stream_m_last_o  = 1'b0;
    stream_s_ready_o = '0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_next      = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx;
          last_grant_next = pick_idx;
`ifdef FX3_STREAM_ARB_HDR_EN
          state_next      = ST_HDR;
`else
          state_next      = ST_XFER;
`endif
        end
      end
`ifdef FX3_STREAM_ARB_HDR_EN
      ST_HDR: begin
        stream_m_data_o  = {HDR_MAGIC, 8'(last_grant_reg)};
        stream_m_valid_o = 1'b1;
        if (stream_m_ready_i) state_next = ST_XFER;
      end
`endif
      ST_XFER: begin
        stream_m_data_o  = ch_data[last_grant_reg];
        stream_m_valid_o = sel_valid;
        stream_m_last_o  = xfer_last;
        stream_s_ready_o = grant_reg & {NUM_CH{stream_m_ready_i}};
        if (sel_valid && stream_m_ready_i) begin
          if (xfer_last) begin
            cnt_next   = '0;
            grant_next = '0;
            state_next = ST_IDLE;
            // Terminated by the length limit rather than by the source.
            split_next = !sel_last;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= PW'(NUM_CH - 1);
      cnt_reg        <= '0;
      split_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      split_reg      <= split_next;
    end
  end

  assign grant_o     = grant_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign pkt_split_o = split_reg;

endmodule

// File: tb/tb_fx3_stream_arb.sv
// Scoreboard bench for fx3_stream_arb (MAX_PKT_LEN=8); header words are
// expected automatically when FX3_STREAM_ARB_HDR_EN is defined.
module tb_fx3_stream_arb;

  localparam int NCH  = 4;
  localparam int MAXL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [16*NCH-1:0] s_data;
  logic [NCH-1:0]    s_valid, s_last, s_ready;
  logic [15:0]       m_data;
  logic              m_valid, m_last, m_ready;
  logic [NCH-1:0]    ch_en, grant;
  logic              busy, pkt_split;

  always #5 clk = ~clk;

  fx3_stream_arb #(
    .NUM_CH      (NCH),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_s_data_i  (s_data),
    .stream_s_valid_i (s_valid),
    .stream_s_last_i  (s_last),
    .stream_s_ready_o (s_ready),
    .stream_m_data_o  (m_data),
    .stream_m_valid_o (m_valid),
    .stream_m_last_o  (m_last),
    .stream_m_ready_i (m_ready),
    .ch_en_i          (ch_en),
    .grant_o          (grant),
    .busy_o           (busy),
    .pkt_split_o      (pkt_split)
  );

  typedef struct packed {
    logic [15:0]    data;
    logic           last;
    logic [NCH-1:0] grant;
  } exp_t;

  exp_t           exp_q[$];
  logic [16:0]    src_q [NCH][$];
  logic           rdy_pat[$];
  int             rdy_idx;
  int             n_tests = 0;
  int             n_fail  = 0;
  int             split_cnt;
  logic           after_last, in_hdr, hold_pend;
  logic [15:0]    hold_data;
  logic [NCH-1:0] prev_grant, forbid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic add_src(input int ch, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++)
      src_q[ch].push_back({(i == n - 1), base + 16'(i)});
  endtask

  // Expected output words for one source packet, split at MAXL words.
  task automatic add_exp(input int ch, input int n, input logic [15:0] base);
    exp_t e;
    int   pos;
    pos = 0;
    e.grant     = '0;
    e.grant[ch] = 1'b1;
    for (int i = 0; i < n; i++) begin
`ifdef FX3_STREAM_ARB_HDR_EN
      if (pos == 0) begin
        e.data = {8'hC5, 8'(ch)};
        e.last = 1'b0;
        exp_q.push_back(e);
      end
`endif
      e.data = base + 16'(i);
      e.last = (i == n - 1) || (pos == MAXL - 1);
      exp_q.push_back(e);
      pos = e.last ? 0 : pos + 1;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (src_q[k].size() != 0) begin
        s_valid[k]        = 1'b1;
        s_data[16*k +: 16] = src_q[k][0][15:0];
        s_last[k]         = src_q[k][0][16];
      end else begin
        s_valid[k]        = 1'b0;
        s_data[16*k +: 16] = 16'h0;
        s_last[k]         = 1'b0;
      end
    end
    if (rdy_pat.size() != 0) begin
      m_ready = rdy_pat[rdy_idx % rdy_pat.size()];
      rdy_idx++;
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic monitor();
    exp_t e;
`ifdef FX3_STREAM_ARB_HDR_EN
    if (grant != '0 && prev_grant == '0) in_hdr = 1'b1;
`endif
    check_val("s_ready", s_ready, in_hdr ? '0 : (grant & {NCH{m_ready}}));
    check_val("busy", busy, grant != '0);
    if (forbid != '0) check_val("forbidden_grant", grant & forbid, '0);
    if (pkt_split) begin
      split_cnt++;
      check_val("split_timing", after_last, 1);
    end
    if (after_last) begin
      check_val("bubble_grant", grant, '0);
      check_val("bubble_valid", m_valid, 0);
      after_last = 1'b0;
    end
    if (hold_pend) begin
      check_val("hold_valid", m_valid, 1);
      check_val("hold_data", m_data, hold_data);
      hold_pend = 1'b0;
    end
    if (m_valid && !m_ready) begin
      hold_pend = 1'b1;
      hold_data = m_data;
    end
    if (m_valid && m_ready) begin
      $display("[TB] out grant=%b data=%h last=%b", grant, m_data, m_last);
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", m_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("data", m_data, e.data);
        check_val("last", m_last, e.last);
        check_val("grant", grant, e.grant);
      end
      if (m_last) after_last = 1'b1;
      in_hdr = 1'b0;
    end
    for (int k = 0; k < NCH; k++)
      if (s_valid[k] && s_ready[k] && src_q[k].size() != 0)
        void'(src_q[k].pop_front());
    prev_grant = grant;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) check_val("drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Reset for one edge; optionally keep sources loaded to model reset mid-packet.
  task automatic do_reset(input bit keep_src);
    rst = 1'b1;
    if (!keep_src) begin
      for (int k = 0; k < NCH; k++) src_q[k].delete();
      drive();
    end
    @(posedge clk);
    #1;
    check_val("rst_valid", m_valid, 0);
    check_val("rst_last", m_last, 0);
    check_val("rst_ready", s_ready, '0);
    check_val("rst_grant", grant, '0);
    check_val("rst_busy", busy, 0);
    check_val("rst_split", pkt_split, 0);
    check_val("rst_data", m_data, 0);
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    exp_q.delete();
    rdy_pat.delete();
    rdy_idx    = 0;
    after_last = 1'b0;
    in_hdr     = 1'b0;
    hold_pend  = 1'b0;
    prev_grant = '0;
    forbid     = '0;
    split_cnt  = 0;
    ch_en      = '1;
    drive();
  endtask

  initial begin
    ch_en   = '1;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;

    // Two simultaneous 4-word packets: ch0 first, then ch2 after a bubble.
    do_reset(0);
    add_src(0, 4, 16'h0A00); add_src(2, 4, 16'h2A00);
    add_exp(0, 4, 16'h0A00); add_exp(2, 4, 16'h2A00);
    drive();
    drain();

    // All channels busy with 3-word packets: order 0,1,2,3,0.
    do_reset(0);
    add_src(0, 3, 16'h0B00); add_src(0, 3, 16'h0B10);
    add_src(1, 3, 16'h1B00); add_src(2, 3, 16'h2B00); add_src(3, 3, 16'h3B00);
    add_exp(0, 3, 16'h0B00); add_exp(1, 3, 16'h1B00); add_exp(2, 3, 16'h2B00);
    add_exp(3, 3, 16'h3B00); add_exp(0, 3, 16'h0B10);
    drive();
    drain();

    // 10-word packet forced to split at 8.
    do_reset(0);
    add_src(1, 10, 16'h1C00); add_exp(1, 10, 16'h1C00);
    drive();
    drain();
    check_val("split_count", split_cnt, 1);

    // Exactly MAXL words ends naturally, no split.
    do_reset(0);
    add_src(3, MAXL, 16'h3D00); add_exp(3, MAXL, 16'h3D00);
    drive();
    drain();
    check_val("no_split_count", split_cnt, 0);

    // Back-pressure pattern 1,0,0,1 on ch0.
    do_reset(0);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    add_src(0, 6, 16'h0E00); add_exp(0, 6, 16'h0E00);
    drive();
    drain();

    // ch1 disabled; ch0 disable mid-packet still completes.
    do_reset(0);
    ch_en  = 4'b1101;
    forbid = 4'b0010;
    add_src(0, 4, 16'h0F00); add_src(1, 2, 16'h1F00);
    add_src(2, 2, 16'h2F00); add_src(3, 2, 16'h3F00);
    add_exp(0, 4, 16'h0F00); add_exp(2, 2, 16'h2F00); add_exp(3, 2, 16'h3F00);
    drive();
    repeat (3) tick();
    ch_en = 4'b1100;
    drain();
    repeat (10) tick();
    forbid = '0;
    ch_en  = '1;
    add_exp(1, 2, 16'h1F00);
    drain();

    // Single-word packets from one channel, re-granted after each bubble.
    do_reset(0);
    add_src(2, 1, 16'h2111); add_src(2, 1, 16'h2222);
    add_exp(2, 1, 16'h2111); add_exp(2, 1, 16'h2222);
    drive();
    drain();

    // ch3 two-word packet (header 0xC503 when enabled).
    do_reset(0);
    src_q[3].push_back({1'b0, 16'h1111}); src_q[3].push_back({1'b1, 16'h2222});
    add_exp(3, 1, 16'h1111);
    exp_q[exp_q.size()-1].last = 1'b0;
    add_exp(3, 1, 16'h2222);
`ifdef FX3_STREAM_ARB_HDR_EN
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_q.push_back(exp_t'({16'h2222, 1'b1, 4'b1000}));
`endif
    drive();
    drain();

    // Reset in the middle of a packet.
    do_reset(0);
    add_src(0, 6, 16'h0123); add_exp(0, 6, 16'h0123);
    drive();
    repeat (4) tick();
    do_reset(1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
